// File: rtl/serial_subtractor_nb.sv
// Digit-serial N-bit subtractor: diff = a - b - bin, D bits per clock, LSB digit first,
// behind a start/busy/done handshake with borrow, zero and signed-overflow flags.
module serial_subtractor_nb #(
    parameter int N = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         zero,
    output logic         ovf
);

    localparam int NDIG = N / D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   a_sh_q, a_sh_d;
    logic [N-1:0]   b_sh_q, b_sh_d;
    logic [N-1:0]   res_q, res_d;
    logic           borrow_q, borrow_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N-1:0]   diff_q, diff_d;
    logic           bout_q, bout_d;
    logic           zero_q, zero_d;
    logic           ovf_q, ovf_d;

    logic [D:0]     sub_s;
    logic [N+D-1:0] res_cat_s;
    logic [N-1:0]   res_next_s;
    logic           accept_s;

    // Next-state, digit datapath and output-register computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        accept_s = 1'b0;

        // Bit D of the widened digit difference is the borrow into the next digit.
        sub_s      = {1'b0, a_sh_q[D-1:0]} - {1'b0, b_sh_q[D-1:0]} - {{D{1'b0}}, borrow_q};
        res_cat_s  = {sub_s[D-1:0], res_q};
        res_next_s = res_cat_s[N+D-1:D];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                res_d    = res_next_s;
                borrow_d = sub_s[D];
                a_sh_d   = a_sh_q >> D;
                b_sh_d   = b_sh_q >> D;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
                    // Last digit: its top bit is the operand sign bit, so ovf is formed here.
                    state_d = S_DONE;
                    diff_d  = res_next_s;
                    bout_d  = sub_s[D];
                    zero_d  = (res_next_s == {N{1'b0}});
                    ovf_d   = (a_sh_q[D-1] != b_sh_q[D-1]) && (sub_s[D-1] != a_sh_q[D-1]);
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept_s) begin
            state_d  = S_RUN;
            cnt_d    = {CW{1'b0}};
            a_sh_d   = a;
            b_sh_d   = b;
            res_d    = {N{1'b0}};
            borrow_d = bin;
        end else begin
            state_d  = state_d;
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            a_sh_q   <= {N{1'b0}};
            b_sh_q   <= {N{1'b0}};
            res_q    <= {N{1'b0}};
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= {N{1'b0}};
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/serial_subtractor_nb.md
# serial_subtractor_nb

Multi-cycle, digit-serial N-bit subtractor computing `diff = a - b - bin` with borrow-out and status flags. It is the inverse arithmetic counterpart of the team's N-bit ripple full adder (`fulladderNb`). It processes D bits per clock, LSB digit first, so area stays small when N is wide. It sits behind a simple start/busy/done handshake in datapaths that subtract.

## Interface
- `N`, default 16: operand and result width.
- `D`, default 4: digit width processed per cycle. D must divide N, 1 ≤ D ≤ N.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `start`  input  1  request; sampled only while accepting (IDLE or DONE).
- `a`  input  N  minuend, captured on accept.
- `b`  input  N  subtrahend, captured on accept.
- `bin`  input  1  borrow-in, captured on accept.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse; result outputs are valid from this cycle onward.
- `diff`  output  N  `(a - b - bin) mod 2^N`.
- `bout`  output  1  unsigned borrow-out; 1 iff `a < b + bin`.
- `zero`  output  1  1 iff `diff == 0`.
- `ovf`  output  1  two's-complement overflow: `a[N-1] != b[N-1]` and `diff[N-1] != a[N-1]`.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:** if `start`=1, capture `a`, `b`, `bin` into internal shift registers, clear the digit counter, and go to RUN. Otherwise stay in IDLE.
- **RUN:** each cycle, subtract the current D-bit digit of `b` plus the running borrow from the current D-bit digit of `a`.
  - Shift the D result bits into the result register.
  - Update the running borrow. Its initial value is the captured `bin`.
  - Increment the counter.
  - After digit N/D−1, go to DONE.
- **DONE (one cycle):** `done`=1.
  - Final `diff`, `bout`, `zero`, `ovf` were registered on the transition into DONE.
  - If `start`=1 in this cycle, accept a new operation and go to RUN (back-to-back). Otherwise go to IDLE.
- **Output hold:** result outputs hold their value until the next transition into DONE. They do not change during a following RUN.
- **Start while busy:** `start` asserted in RUN is ignored and is not queued. Input changes during RUN have no effect.
- **Internal widths:** the digit subtract is D+1 bits wide; bit D of each digit result is the borrow into the next digit.

## Timing
- **Reset values:** when `rst_n`=0 at a rising edge, next state is IDLE, and `busy`, `done`, `diff`, `bout`, `zero`, `ovf` are all 0. The counter and operand registers are cleared.
- **Reset mid-RUN:** aborts the operation. No `done` pulse follows, and outputs go to 0.
- **Latency:** `start` sampled high in cycle 0 (from IDLE or DONE) gives:
  - `busy`=1 in cycles 1 through N/D;
  - `done`=1 and results valid in cycle N/D+1.
- **Throughput:** for N=16, D=4, latency is 5 cycles. Back-to-back throughput is one result per N/D+1 cycles.
- **D=N:** RUN lasts exactly one cycle.
- **`busy` and `done`** are never high in the same cycle.

## Test plan
- **Basic subtract:** N=16, D=4. `a`=0x0005, `b`=0x0003, `bin`=0, start pulse → `done` in cycle 5 with `diff`=0x0002, `bout`=0, `zero`=0, `ovf`=0. `busy` is high in cycles 1–4 only.
- **Borrow and zero:**
  - `a`=0x0003, `b`=0x0005, `bin`=0 → `diff`=0xFFFE, `bout`=1.
  - `a`=0x0000, `b`=0xFFFF, `bin`=1 → `diff`=0x0000, `bout`=1, `zero`=1.
- **Signed overflow:**
  - `a`=0x8000, `b`=0x0001, `bin`=0 → `diff`=0x7FFF, `ovf`=1, `bout`=0.
  - `a`=0x1234, `b`=0x1234, `bin`=0 → `zero`=1, `ovf`=0.
- **Handshake:**
  - `start` held during RUN with changing `a`/`b` → result matches the captured operands, with exactly one `done`.
  - `start` in the DONE cycle → second `done` exactly 5 cycles later.
  - Outputs stay stable between `done` pulses.
- **Reset mid-operation:** `rst_n`=0 for one edge during RUN cycle 2 → next cycle all outputs are 0 and state is IDLE. No `done` pulse appears, and a new `start` then completes normally.
- **Randomized check:** 10k random `a`, `b`, `bin` for (N,D) ∈ {(16,4), (16,1), (16,16), (12,3)}. Compare against a reference model of `{bout,diff} = {1'b0,a} - b - bin`, plus the `zero`/`ovf` formulas above.
